// File: rtl/grant_locking_arbiter_4_pkg.sv
// Shared constants, state encoding and burst classification for the
// four-input grant-locking arbiter.
package grant_locking_arbiter_4_pkg;

    localparam logic [3:0] G_TYPE_GET_DATA_BLOCK   = 4'h5;
    localparam logic [3:0] G_TYPE_NONBUILTIN_BURST = 4'h0;

    localparam int DEFAULT_BEAT_BITS = 3;
    localparam int BEATS_PER_BURST   = 1 << DEFAULT_BEAT_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Builtin grants burst only for GET_DATA_BLOCK; non-builtin only for type 0.
    function automatic logic isBurstBeat(input logic isBuiltin, input logic [3:0] gType);
        return isBuiltin ? (gType == G_TYPE_GET_DATA_BLOCK)
                         : (gType == G_TYPE_NONBUILTIN_BURST);
    endfunction

endpackage

// File: rtl/grant_locking_arbiter_4_rr_pick_4.sv
// Combinational round-robin picker: first valid index after 'last', wrapping mod 4.
module rr_pick_4 (
    input  logic [3:0] valid,
    input  logic [1:0] last,
    output logic [1:0] sel,
    output logic       any
);

    // Scan from the farthest offset down so the nearest valid index wins.
    always_comb begin
        sel = last;
        any = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (valid[2'(last + 2'(i))]) begin
                sel = 2'(last + 2'(i));
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grant_locking_arbiter_4.sv
// Four-input round-robin grant arbiter that locks onto a requester for the
// full length of a multi-beat burst, feeding a one-entry output register.
module grant_locking_arbiter_4
    import grant_locking_arbiter_4_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int BEAT_BITS = DEFAULT_BEAT_BITS
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              io_in_0_valid,
    output logic              io_in_0_ready,
    input  logic [2:0]        io_in_0_bits_addr_beat,
    input  logic [1:0]        io_in_0_bits_client_xact_id,
    input  logic              io_in_0_bits_manager_xact_id,
    input  logic              io_in_0_bits_is_builtin_type,
    input  logic [3:0]        io_in_0_bits_g_type,
    input  logic [DATA_W-1:0] io_in_0_bits_data,

    input  logic              io_in_1_valid,
    output logic              io_in_1_ready,
    input  logic [2:0]        io_in_1_bits_addr_beat,
    input  logic [1:0]        io_in_1_bits_client_xact_id,
    input  logic              io_in_1_bits_manager_xact_id,
    input  logic              io_in_1_bits_is_builtin_type,
    input  logic [3:0]        io_in_1_bits_g_type,
    input  logic [DATA_W-1:0] io_in_1_bits_data,

    input  logic              io_in_2_valid,
    output logic              io_in_2_ready,
    input  logic [2:0]        io_in_2_bits_addr_beat,
    input  logic [1:0]        io_in_2_bits_client_xact_id,
    input  logic              io_in_2_bits_manager_xact_id,
    input  logic              io_in_2_bits_is_builtin_type,
    input  logic [3:0]        io_in_2_bits_g_type,
    input  logic [DATA_W-1:0] io_in_2_bits_data,

    input  logic              io_in_3_valid,
    output logic              io_in_3_ready,
    input  logic [2:0]        io_in_3_bits_addr_beat,
    input  logic [1:0]        io_in_3_bits_client_xact_id,
    input  logic              io_in_3_bits_manager_xact_id,
    input  logic              io_in_3_bits_is_builtin_type,
    input  logic [3:0]        io_in_3_bits_g_type,
    input  logic [DATA_W-1:0] io_in_3_bits_data,

    input  logic              io_out_ready,
    output logic              io_out_valid,
    output logic [2:0]        io_out_bits_addr_beat,
    output logic [1:0]        io_out_bits_client_xact_id,
    output logic              io_out_bits_manager_xact_id,
    output logic              io_out_bits_is_builtin_type,
    output logic [3:0]        io_out_bits_g_type,
    output logic [DATA_W-1:0] io_out_bits_data,
    output logic [1:0]        io_chosen
);

    typedef struct packed {
        logic [2:0]        addrBeat;
        logic [1:0]        clientXactId;
        logic              managerXactId;
        logic              isBuiltinType;
        logic [3:0]        gType;
        logic [DATA_W-1:0] data;
    } beat_t;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = '1;

    arb_state_e           state_q, state_d;
    logic [BEAT_BITS-1:0] count_q, count_d;
    logic [1:0]           lockIdx_q, lockIdx_d;
    logic [1:0]           lastGrant_q, lastGrant_d;

    logic                 outValid_q;
    beat_t                outBeat_q;
    logic [1:0]           chosen_q;

    beat_t                inBeat [4];
    logic [3:0]           inValid;
    logic [3:0]           inReady;
    logic [1:0]           rrSel;
    logic                 rrAny;
    logic [1:0]           sel;
    logic                 selValid;
    beat_t                selBeat;
    logic                 loadEn;
    logic                 acceptEn;

    assign inValid   = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
    assign inBeat[0] = {io_in_0_bits_addr_beat, io_in_0_bits_client_xact_id, io_in_0_bits_manager_xact_id,
                        io_in_0_bits_is_builtin_type, io_in_0_bits_g_type, io_in_0_bits_data};
    assign inBeat[1] = {io_in_1_bits_addr_beat, io_in_1_bits_client_xact_id, io_in_1_bits_manager_xact_id,
                        io_in_1_bits_is_builtin_type, io_in_1_bits_g_type, io_in_1_bits_data};
    assign inBeat[2] = {io_in_2_bits_addr_beat, io_in_2_bits_client_xact_id, io_in_2_bits_manager_xact_id,
                        io_in_2_bits_is_builtin_type, io_in_2_bits_g_type, io_in_2_bits_data};
    assign inBeat[3] = {io_in_3_bits_addr_beat, io_in_3_bits_client_xact_id, io_in_3_bits_manager_xact_id,
                        io_in_3_bits_is_builtin_type, io_in_3_bits_g_type, io_in_3_bits_data};

    rr_pick_4 u_pick (
        .valid (inValid),
        .last  (lastGrant_q),
        .sel   (rrSel),
        .any   (rrAny)
    );

    // While locked the owner keeps the slot even when idle, producing bubbles.
    always_comb begin
        sel      = rrSel;
        selValid = rrAny;
        if (state_q == LOCKED) begin
            sel      = lockIdx_q;
            selValid = inValid[lockIdx_q];
        end
    end

    assign selBeat  = inBeat[sel];
    assign loadEn   = !outValid_q || io_out_ready;
    assign acceptEn = loadEn && selValid && !reset;
    assign inReady  = acceptEn ? (4'b0001 << sel) : 4'b0000;

    assign io_in_0_ready = inReady[0];
    assign io_in_1_ready = inReady[1];
    assign io_in_2_ready = inReady[2];
    assign io_in_3_ready = inReady[3];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lockIdx_d   = lockIdx_q;
        lastGrant_d = lastGrant_q;
        if (acceptEn) begin
            lastGrant_d = sel;
            case (state_q)
                IDLE: begin
                    if (isBurstBeat(selBeat.isBuiltinType, selBeat.gType)) begin
                        state_d   = LOCKED;
                        lockIdx_d = sel;
                        count_d   = BEAT_BITS'(1);
                    end
                end
                LOCKED: begin
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Last grant starts at 3 so requester 0 has first priority out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            lockIdx_q   <= 2'd0;
            lastGrant_q <= 2'd3;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lockIdx_q   <= lockIdx_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outBeat_q  <= '0;
            chosen_q   <= 2'd0;
        end else if (acceptEn) begin
            outValid_q <= 1'b1;
            outBeat_q  <= selBeat;
            chosen_q   <= sel;
        end else if (io_out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign io_out_valid                = outValid_q;
    assign io_out_bits_addr_beat       = outBeat_q.addrBeat;
    assign io_out_bits_client_xact_id  = outBeat_q.clientXactId;
    assign io_out_bits_manager_xact_id = outBeat_q.managerXactId;
    assign io_out_bits_is_builtin_type = outBeat_q.isBuiltinType;
    assign io_out_bits_g_type          = outBeat_q.gType;
    assign io_out_bits_data            = outBeat_q.data;
    assign io_chosen                   = chosen_q;

endmodule

// File: tb/tb_grant_locking_arbiter_4.sv
// Self-checking bench: a vector table for round-robin readiness plus scoreboarded
// multi-cycle sequences for bursts, backpressure, bubbles and mid-burst reset.
module tb_grant_locking_arbiter_4;

    localparam int DATA_W = 64;

    typedef struct {
        logic [3:0] valid;
        logic       outReady;
        logic [3:0] expReady;
        logic       expOutValid;
        logic [1:0] expChosen;
    } vec_t;

    typedef struct {
        logic [1:0]        chosen;
        logic [2:0]        addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        inValid;
    logic [3:0]        inReady;
    logic [2:0]        inAddr     [4];
    logic [1:0]        inClient   [4];
    logic              inMgr      [4];
    logic              inBuiltin  [4];
    logic [3:0]        inGType    [4];
    logic [DATA_W-1:0] inData     [4];
    logic              outReady;
    logic              outValid;
    logic [2:0]        outAddr;
    logic [1:0]        outClient;
    logic              outMgr;
    logic              outBuiltin;
    logic [3:0]        outGType;
    logic [DATA_W-1:0] outData;
    logic [1:0]        chosen;

    int                remaining  [4];
    int                beatCnt    [4];
    logic              hold       [4];
    logic              cfgBuiltin [4];
    logic [3:0]        cfgGType   [4];
    exp_t              sbQ[$];
    logic              sbOn;
    int                checks;
    int                errors;
    vec_t              vecs [15];

    always #5 clk = ~clk;

    grant_locking_arbiter_4 #(.DATA_W(DATA_W), .BEAT_BITS(3)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .io_in_0_valid                (inValid[0]),
        .io_in_0_ready                (inReady[0]),
        .io_in_0_bits_addr_beat       (inAddr[0]),
        .io_in_0_bits_client_xact_id  (inClient[0]),
        .io_in_0_bits_manager_xact_id (inMgr[0]),
        .io_in_0_bits_is_builtin_type (inBuiltin[0]),
        .io_in_0_bits_g_type          (inGType[0]),
        .io_in_0_bits_data            (inData[0]),
        .io_in_1_valid                (inValid[1]),
        .io_in_1_ready                (inReady[1]),
        .io_in_1_bits_addr_beat       (inAddr[1]),
        .io_in_1_bits_client_xact_id  (inClient[1]),
        .io_in_1_bits_manager_xact_id (inMgr[1]),
        .io_in_1_bits_is_builtin_type (inBuiltin[1]),
        .io_in_1_bits_g_type          (inGType[1]),
        .io_in_1_bits_data            (inData[1]),
        .io_in_2_valid                (inValid[2]),
        .io_in_2_ready                (inReady[2]),
        .io_in_2_bits_addr_beat       (inAddr[2]),
        .io_in_2_bits_client_xact_id  (inClient[2]),
        .io_in_2_bits_manager_xact_id (inMgr[2]),
        .io_in_2_bits_is_builtin_type (inBuiltin[2]),
        .io_in_2_bits_g_type          (inGType[2]),
        .io_in_2_bits_data            (inData[2]),
        .io_in_3_valid                (inValid[3]),
        .io_in_3_ready                (inReady[3]),
        .io_in_3_bits_addr_beat       (inAddr[3]),
        .io_in_3_bits_client_xact_id  (inClient[3]),
        .io_in_3_bits_manager_xact_id (inMgr[3]),
        .io_in_3_bits_is_builtin_type (inBuiltin[3]),
        .io_in_3_bits_g_type          (inGType[3]),
        .io_in_3_bits_data            (inData[3]),
        .io_out_ready                 (outReady),
        .io_out_valid                 (outValid),
        .io_out_bits_addr_beat        (outAddr),
        .io_out_bits_client_xact_id   (outClient),
        .io_out_bits_manager_xact_id  (outMgr),
        .io_out_bits_is_builtin_type  (outBuiltin),
        .io_out_bits_g_type           (outGType),
        .io_out_bits_data             (outData),
        .io_chosen                    (chosen)
    );

    function automatic logic [DATA_W-1:0] dataTag(input int n, input int b);
        return 64'hA5A5_0000_0000_0000 | (64'(n) << 16) | 64'(b);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic driveSources();
        for (int n = 0; n < 4; n++) begin
            inValid[n]   = (remaining[n] > 0) && !hold[n];
            inAddr[n]    = 3'(beatCnt[n]);
            inClient[n]  = 2'(n);
            inMgr[n]     = beatCnt[n][0];
            inBuiltin[n] = cfgBuiltin[n];
            inGType[n]   = cfgGType[n];
            inData[n]    = dataTag(n, beatCnt[n]);
        end
    endtask

    task automatic pushBeats(input int n, input int first, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            sbQ.push_back('{2'(n), 3'(first + k), dataTag(n, first + k)});
        end
    endtask

    // One clock: handshakes are sampled at the falling edge, sources advance just after the rising edge.
    task automatic tick();
        logic [3:0] fire;
        exp_t       e;
        @(negedge clk);
        fire = inReady & inValid;
        if (sbOn && outValid && outReady) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got beat chosen=%0d addr=%0d, expected none", chosen, outAddr);
            end else begin
                e = sbQ.pop_front();
                check("sb_chosen", 64'(chosen), 64'(e.chosen));
                check("sb_addr_beat", 64'(outAddr), 64'(e.addr));
                check("sb_data", outData, e.data);
            end
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) begin
            if (fire[n]) begin
                beatCnt[n]++;
                remaining[n]--;
            end
        end
        driveSources();
    endtask

    task automatic runUntilDrained(input string name, input int budget);
        int b = 0;
        while (sbQ.size() > 0 && b < budget) begin
            tick();
            b++;
        end
        check(name, 64'(sbQ.size()), 64'd0);
    endtask

    task automatic doReset();
        reset    = 1'b1;
        outReady = 1'b0;
        sbOn     = 1'b0;
        sbQ.delete();
        for (int n = 0; n < 4; n++) begin
            remaining[n]  = 0;
            beatCnt[n]    = 0;
            hold[n]       = 1'b0;
            cfgBuiltin[n] = 1'b1;
            cfgGType[n]   = 4'h0;
        end
        driveSources();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 15; i++) begin
            for (int n = 0; n < 4; n++) hold[n] = !vecs[i].valid[n];
            outReady = vecs[i].outReady;
            driveSources();
            #2;
            check($sformatf("vec%0d_ready", i), 64'(inReady), 64'(vecs[i].expReady));
            tick();
            check($sformatf("vec%0d_out_valid", i), 64'(outValid), 64'(vecs[i].expOutValid));
            check($sformatf("vec%0d_chosen", i), 64'(chosen), 64'(vecs[i].expChosen));
        end
    endtask

    task automatic checkOutput(input string name, input logic [1:0] expChosen,
                               input logic [2:0] expAddr, input logic [DATA_W-1:0] expData);
        check({name, "_ready"}, 64'(inReady), 64'd0);
        check({name, "_chosen"}, 64'(chosen), 64'(expChosen));
        check({name, "_addr"}, 64'(outAddr), 64'(expAddr));
        check({name, "_data"}, outData, expData);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bud;
        checks = 0;
        errors = 0;
        sbOn   = 1'b0;

        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[6]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[8]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[10] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[12] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[13] = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};

        // Reset held with every requester valid: outputs cleared, nothing granted.
        reset    = 1'b1;
        outReady = 1'b1;
        for (int n = 0; n < 4; n++) begin
            remaining[n]  = 100;
            beatCnt[n]    = 0;
            hold[n]       = 1'b0;
            cfgBuiltin[n] = 1'b1;
            cfgGType[n]   = 4'h0;
        end
        driveSources();
        #2;
        check("rst_out_valid", 64'(outValid), 64'd0);
        check("rst_client", 64'(outClient), 64'd0);
        check("rst_mgr_builtin", 64'({outMgr, outBuiltin}), 64'd0);
        check("rst_gtype", 64'(outGType), 64'd0);
        checkOutput("rst", 2'd0, 3'd0, '0);
        @(posedge clk);
        #1;
        check("rst_held_ready", 64'(inReady), 64'd0);
        check("rst_held_out_valid", 64'(outValid), 64'd0);
        reset = 1'b0;

        applyStimulus();

        // in0 bursts 8 beats while in1 waits; in0's next burst then blocks in1 with bubbles.
        doReset();
        sbOn        = 1'b1;
        outReady    = 1'b1;
        cfgGType[0] = 4'h5;
        remaining[0] = 9;
        remaining[1] = 2;
        driveSources();
        pushBeats(0, 0, 8);
        pushBeats(1, 0, 1);
        pushBeats(0, 8, 1);
        runUntilDrained("burst_drain", 60);
        repeat (6) tick();
        #2;
        check("lock_bubble_ready", 64'(inReady), 64'd0);
        check("lock_bubble_in1_left", 64'(remaining[1]), 64'd1);

        // Backpressure with the register full: no accepts and a stable payload.
        doReset();
        sbOn     = 1'b1;
        outReady = 1'b1;
        for (int n = 0; n < 4; n++) remaining[n] = 3;
        driveSources();
        for (int b = 0; b < 3; b++) begin
            for (int n = 0; n < 4; n++) pushBeats(n, b, 1);
        end
        tick();
        tick();
        outReady = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #2;
            checkOutput($sformatf("stall%0d", s), 2'd1, 3'd0, dataTag(1, 0));
            tick();
        end
        outReady = 1'b1;
        runUntilDrained("stall_drain", 60);

        // in2 locked, drops valid at count 4 while in3 waits; burst resumes at beat 4.
        doReset();
        sbOn        = 1'b1;
        outReady    = 1'b1;
        cfgGType[2] = 4'h5;
        remaining[2] = 8;
        remaining[3] = 2;
        driveSources();
        pushBeats(2, 0, 8);
        pushBeats(3, 0, 2);
        bud = 0;
        while (beatCnt[2] < 4 && bud < 40) begin
            tick();
            bud++;
        end
        check("gap_reach_count4", 64'(beatCnt[2]), 64'd4);
        hold[2] = 1'b1;
        driveSources();
        for (int s = 0; s < 2; s++) begin
            #2;
            check($sformatf("gap%0d_no_grant", s), 64'(inReady), 64'd0);
            tick();
        end
        hold[2] = 1'b0;
        driveSources();
        runUntilDrained("gap_drain", 60);

        // Reset in the middle of an in1 burst abandons it; in0 wins first afterwards.
        doReset();
        outReady    = 1'b1;
        cfgGType[1] = 4'h5;
        remaining[1] = 8;
        driveSources();
        bud = 0;
        while (beatCnt[1] < 5 && bud < 40) begin
            tick();
            bud++;
        end
        check("midrst_reach_count5", 64'(beatCnt[1]), 64'd5);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(outValid), 64'd0);
        check("midrst_ready", 64'(inReady), 64'd0);
        remaining[0] = 1;
        remaining[1] = 3;
        driveSources();
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbOn  = 1'b1;
        pushBeats(0, 0, 1);
        pushBeats(1, 5, 3);
        runUntilDrained("midrst_drain", 40);

        // Non-builtin: g_type 0 on in3 locks for 8 beats, g_type 1 on in1 never locks.
        doReset();
        sbOn          = 1'b1;
        outReady      = 1'b1;
        cfgBuiltin[3] = 1'b0;
        cfgGType[3]   = 4'h0;
        remaining[3]  = 8;
        cfgBuiltin[1] = 1'b0;
        cfgGType[1]   = 4'h1;
        remaining[1]  = 2;
        driveSources();
        pushBeats(1, 0, 1);
        pushBeats(3, 0, 8);
        pushBeats(1, 1, 1);
        runUntilDrained("nb_drain", 60);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grant_locking_arbiter_4.md
GRANT_LOCKING_ARBITER_4 -- requirements
Module: grant_locking_arbiter_4

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning grant data width.
REQ-002 SHALL have parameter BEAT_BITS, default 3, meaning beat-counter width; beats per burst = 2^BEAT_BITS.
REQ-003 SHALL have `clk`, input, 1 bit: the single clock.
REQ-004 SHALL have `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have, for each n = 0..3, `io_in_n_valid`, input, 1 bit: requester n offers a beat.
REQ-006 SHALL have, for each n = 0..3, `io_in_n_ready`, output, 1 bit: requester n beat accepted this cycle.
REQ-007 SHALL have, for each n = 0..3, `io_in_n_bits_{addr_beat[2:0], client_xact_id[1:0], manager_xact_id, is_builtin_type, g_type[3:0], data[DATA_W-1:0]}`, all inputs: the grant payload.
REQ-008 SHALL have `io_out_ready`, input, 1 bit: downstream accepts.
REQ-009 SHALL have `io_out_valid`, output, 1 bit: registered beat present.
REQ-010 SHALL have `io_out_bits_*`, outputs, same fields and widths as the inputs: the registered payload.
REQ-011 SHALL have `io_chosen`, output, 2 bits: index of the requester whose beat is in the output register.

Function
REQ-012 SHALL use a one-entry output register; a beat SHALL be loaded when the register is empty or io_out_ready=1 in the same cycle (full throughput, 1-cycle latency).
REQ-013 SHALL define load_en = !io_out_valid | io_out_ready; io_in_n_ready SHALL equal load_en & (n == sel), and SHALL be 0 for all non-selected n.
REQ-014 SHALL operate state IDLE by round-robin: sel is the first valid index scanning lastGrant+1, lastGrant+2, ... mod 4; when no input is valid, no ready is asserted.
REQ-015 SHALL define a burst beat as is_builtin_type ? (g_type==4'h5) : (g_type==4'h0).
REQ-016 SHALL, in IDLE on acceptance of a burst beat, go to LOCKED, record lockIdx=sel, and set count=1.
REQ-017 SHALL, in LOCKED, set sel=lockIdx regardless of other valids, and increment count on each accepted beat.
REQ-018 SHALL return to IDLE when a beat is accepted with count == 2^BEAT_BITS-1, at which point count wraps to 0.
REQ-019 SHALL, when a non-burst beat is accepted in IDLE, remain in IDLE with count unchanged.
REQ-020 SHALL update lastGrant=sel on every accepted beat (IDLE or LOCKED).
REQ-021 SHALL hold io_out_bits and io_chosen stable while io_out_valid=1 and io_out_ready=0.
REQ-022 SHALL NOT accept a new beat while io_out_valid=1 and io_out_ready=0.
REQ-023 SHALL, in LOCKED with lockIdx invalid, insert bubbles and SHALL NOT grant any other requester.

Reset
REQ-024 SHALL on reset force state=IDLE, count=0, lockIdx=0, and lastGrant=3 (so requester 0 has first priority).
REQ-025 SHALL on reset force io_out_valid=0, all io_out_bits_*=0, io_chosen=0, and all io_in_n_ready=0 while reset is held.
REQ-026 SHALL, on reset asserted mid-burst, abandon the burst; after release, arbitration SHALL restart fresh in IDLE.

Structure
REQ-027 SHALL place the g_type constants (GET_DATA_BLOCK=5, non-builtin burst=0), the state enum (IDLE, LOCKED) and the beats-per-burst constant in a shared package.
REQ-028 SHALL implement the round-robin picker as the combinational sub-module rr_pick_4 (inputs: valid[3:0], last[1:0]; outputs: sel[1:0], any).

Verification
REQ-029 SHALL cover: all four valid, non-burst (builtin, g_type=0), io_out_ready=1 -> io_chosen sequence 0,1,2,3,0; io_out_valid=1 from the cycle after the first accept.
REQ-030 SHALL cover: in0 burst (builtin, g_type=5) for 8 beats plus in1 valid -> io_chosen=0 for 8 consecutive beats, addr_beat 0..7 preserved, then io_chosen=1.
REQ-031 SHALL cover: io_out_ready=0 for 3 cycles with the register full -> all io_in_n_ready=0, io_out_bits unchanged; one beat lost or duplicated is a failure.
REQ-032 SHALL cover: LOCKED on in2 at count=4, in2 drops valid for 2 cycles while in3 is valid -> no grant to in3; burst resumes at count=4.
REQ-033 SHALL cover: reset asserted at count=5 of an in1 burst -> io_out_valid=0 immediately; after release with in0 and in1 valid, the first grant is in0.
REQ-034 SHALL cover: non-builtin g_type=0 burst on in3 -> locks for 8 beats; non-builtin g_type=1 -> single beat, no lock.
